// File: rtl/ring_decoder.sv
// Receive-side checker for a rotating one-hot ring word: decodes the bit position,
// locks after a run of correct rotations, counts laps and latches a sticky fault.
module ring_decoder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LAP_W    = 8,
    parameter int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             init,
    input  logic             en,
    input  logic [WIDTH-1:0] ring,
    output logic [IDX_W-1:0] index,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [LAP_W-1:0] lap_count
);

    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               onehot_c;
    logic [IDX_W-1:0]   idx_c;
    logic [IDX_W-1:0]   next_idx_c;
    logic               step_ok_c;
    logic               wrap_c;

    // Per-sample decode of the ring word against the last accepted position
    always_comb begin
        onehot_c = (ring != '0) && ((ring & (ring - WIDTH'(1))) == '0);
        idx_c    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (ring[i]) idx_c = IDX_W'(i);
        end
        next_idx_c = (prev_idx_q == IDX_W'(WIDTH - 1)) ? '0 : prev_idx_q + IDX_W'(1);
        step_ok_c  = onehot_c && (idx_c == next_idx_c);
        wrap_c     = (prev_idx_q == IDX_W'(WIDTH - 1)) && (idx_c == '0);
    end

    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        index_d    = index_q;
        run_cnt_d  = run_cnt_q;
        lap_d      = lap_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (en) begin
            unique case (state_q)
                SEARCH: begin
                    if (onehot_c) begin
                        prev_idx_d = idx_c;
                        index_d    = idx_c;
                        run_cnt_d  = RUN_W'(1);
                        state_d    = (LOCK_CNT == 1) ? LOCKED : TRACK;
                    end
                end
                TRACK: begin
                    if (step_ok_c) begin
                        prev_idx_d = idx_c;
                        index_d    = idx_c;
                        run_cnt_d  = run_cnt_q + RUN_W'(1);
                        if (run_cnt_q + RUN_W'(1) == RUN_W'(LOCK_CNT)) state_d = LOCKED;
                    end else if (onehot_c) begin
                        prev_idx_d = idx_c;
                        index_d    = idx_c;
                        run_cnt_d  = RUN_W'(1);
                    end else begin
                        run_cnt_d  = '0;
                        state_d    = SEARCH;
                    end
                end
                LOCKED: begin
                    if (step_ok_c) begin
                        prev_idx_d = idx_c;
                        index_d    = idx_c;
                        if (wrap_c) lap_d = lap_q + LAP_W'(1);
                    end else begin
                        state_d    = FAULT;
                        err_d      = 1'b1;
                        err_code_d = onehot_c ? 2'b10 : 2'b01;
                    end
                end
                FAULT: begin
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q    <= SEARCH;
            prev_idx_q <= '0;
            index_q    <= '0;
            run_cnt_q  <= '0;
            lap_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            prev_idx_q <= prev_idx_d;
            index_q    <= index_d;
            run_cnt_q  <= run_cnt_d;
            lap_q      <= lap_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign index     = index_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign lap_count = lap_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder: a driver feeds directed and random ring words,
// a behavioural model queues expected outputs, a monitor compares after each edge.
module tb_ring_decoder;

    localparam int unsigned W     = 8;
    localparam int unsigned LOCKN = 3;
    localparam int unsigned LAPW  = 8;
    localparam int unsigned IW    = $clog2(W);

    typedef struct {
        int unsigned index;
        bit          locked;
        bit          err;
        int unsigned err_code;
        int unsigned lap;
    } exp_t;

    logic            clk = 1'b0;
    logic            init;
    logic            en;
    logic [W-1:0]    ring;
    logic [IW-1:0]   index;
    logic            locked;
    logic            err;
    logic [1:0]      err_code;
    logic [LAPW-1:0] lap_count;

    int passes = 0;
    int checks = 0;
    exp_t exp_q[$];

    // Reference model: plain bookkeeping of the decoder's rules
    bit          m_faulted, m_locked;
    int unsigned m_run, m_prev, m_index, m_code, m_lap;

    ring_decoder #(.WIDTH(W), .LOCK_CNT(LOCKN), .LAP_W(LAPW)) dut (
        .clk(clk), .init(init), .en(en), .ring(ring),
        .index(index), .locked(locked), .err(err),
        .err_code(err_code), .lap_count(lap_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input int unsigned p);
        logic [W-1:0] one;
        one = W'(1);
        return one << (p % W);
    endfunction

    task automatic model(input bit i_init, input bit i_en, input logic [W-1:0] r);
        bit          oh;
        int unsigned pos;
        oh  = ($countones(r) == 1);
        pos = oh ? $clog2(r) : 0;
        if (i_init) begin
            m_faulted = 0; m_locked = 0; m_run = 0; m_prev = 0;
            m_index = 0; m_code = 0; m_lap = 0;
        end else if (i_en && !m_faulted) begin
            if (m_locked) begin
                if (oh && pos == (m_prev + 1) % W) begin
                    if (m_prev == W - 1 && pos == 0) m_lap = (m_lap + 1) % (1 << LAPW);
                    m_prev = pos; m_index = pos;
                end else begin
                    m_faulted = 1; m_locked = 0;
                    m_code = oh ? 2 : 1;
                end
            end else if (oh) begin
                if (m_run > 0 && pos == (m_prev + 1) % W) m_run++;
                else m_run = 1;
                m_prev = pos; m_index = pos;
                if (m_run >= LOCKN) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input bit i_init, input bit i_en, input logic [W-1:0] r);
        exp_t e;
        @(negedge clk);
        init = i_init; en = i_en; ring = r;
        model(i_init, i_en, r);
        e.index = m_index; e.locked = m_locked; e.err = m_faulted;
        e.err_code = m_code; e.lap = m_lap;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Monitor: every edge presents a new output set
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("index", 32'(index), e.index);
            chk("locked", 32'(locked), 32'(e.locked));
            chk("err", 32'(err), 32'(e.err));
            chk("err_code", 32'(err_code), e.err_code);
            chk("lap_count", 32'(lap_count), e.lap);
        end
    end

    initial begin
        int unsigned p;
        int unsigned r;
        bit          nxt_en;
        init = 1'b1; en = 1'b0; ring = '0;
        m_faulted = 0; m_locked = 0; m_run = 0; m_prev = 0;
        m_index = 0; m_code = 0; m_lap = 0;

        // Shared init, lock on the third word, then two laps
        step(1, 0, '0);
        step(0, 1, 8'h80);
        step(0, 1, 8'h01);
        step(0, 1, 8'h02);
        for (int k = 2; k < 19; k++) step(0, 1, word(k + 1));
        // Zero word faults; good data is ignored until init (which beats en)
        step(0, 1, 8'h00);
        for (int k = 0; k < 10; k++) step(0, 1, word(k));
        step(1, 1, 8'h01);

        // Stalled value while locked
        step(0, 1, 8'h80);
        step(0, 1, 8'h01);
        step(0, 1, 8'h02);
        step(0, 1, 8'h04);
        step(0, 1, 8'h08);
        step(0, 1, 8'h08);
        step(1, 0, '0);

        // Pre-lock glitch, then en gating with arbitrary ring contents
        step(0, 1, 8'h80);
        step(0, 1, 8'h01);
        step(0, 1, 8'h03);
        step(0, 1, 8'h04);
        step(0, 1, 8'h08);
        step(0, 1, 8'h10);
        step(0, 1, 8'h20);
        for (int k = 0; k < 5; k++) step(0, 0, W'($urandom));
        step(0, 1, 8'h40);
        step(0, 1, 8'h80);
        step(0, 1, 8'h01);
        step(1, 0, '0);

        // Random run: mostly correct rotation, occasional corruption, en gaps, inits
        p = W - 2;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            nxt_en = ($urandom_range(0, 9) != 0);
            if (r < 2) begin
                step(1, nxt_en, W'($urandom));
                p = W - 2;
            end else if (r < 5) begin
                step(0, nxt_en, W'($urandom));
            end else if (r < 7) begin
                step(0, nxt_en, word(p));
            end else begin
                step(0, nxt_en, word(p + 1));
                if (nxt_en) p = (p + 1) % W;
            end
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected samples never compared", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side checker for the rotating one-hot ring counter bus. It samples an 8-bit one-hot ring word and decodes the set-bit position to a binary index. It declares lock after a run of correct rotations, counts full laps and flags any corruption with a sticky error. It sits downstream of the ring counter and drives status logic that must trust the ring phase.

## Interface
- WIDTH, 8, ring width in bits; minimum 2.
- LOCK_CNT, 3, consecutive correct one-hot samples required to lock; minimum 1.
- LAP_W, 8, lap counter width.
- IDX_W, $clog2(WIDTH), derived index width; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- init  input  1  synchronous, active-high reset; has priority over everything.
- en  input  1  sample enable; `ring` is evaluated only on edges where en=1.
- ring  input  WIDTH  ring word from the counter.
- index  output  IDX_W  position of the set bit in the last accepted sample.
- locked  output  1  high while in LOCKED.
- err  output  1  sticky fault flag.
- err_code  output  2  01 = not one-hot (zero or multiple bits set); 10 = wrong step; 00 = no fault.
- lap_count  output  LAP_W  number of WIDTH-1→0 wraps accepted while locked; wraps modulo 2^LAP_W.

## Operation
- One clock and one reset: the reset is synchronous and active-high.
- Rotation convention: the set bit moves from position p to (p+1) mod WIDTH each sample. 10000000 → 00000001 → 00000010 and so on.
- Combinational per sample:
  - onehot = exactly one bit set.
  - idx = position of that bit.
  - step_ok = onehot and idx == (prev_idx+1) mod WIDTH.
- The FSM has four states: SEARCH, TRACK, LOCKED and FAULT. run_cnt counts consecutive correct samples.
- SEARCH:
  - onehot sample: prev_idx←idx, index←idx, run_cnt←1. Go to LOCKED if LOCK_CNT=1, otherwise go to TRACK.
  - non-one-hot sample: stay in SEARCH. No error is raised.
- TRACK:
  - step_ok: prev_idx←idx, index←idx, run_cnt++. When run_cnt reaches LOCK_CNT, go to LOCKED.
  - onehot but not step_ok: restart the run at the new idx with run_cnt←1 and stay in TRACK.
  - non-one-hot: go to SEARCH with run_cnt←0.
  - Errors are never raised before lock.
- LOCKED:
  - step_ok: prev_idx←idx, index←idx. If prev_idx was WIDTH-1 and idx is 0, lap_count++.
  - Any other sample: go to FAULT. err←1. err_code←01 if the sample is not one-hot, else 10. A repeated (stalled) value counts as 10.
  - index keeps the last good value on a fault.
- FAULT:
  - Absorbing; only init exits.
  - err=1 and err_code are held, locked=0. index and lap_count are frozen.
  - Further samples are ignored.
- en=0: no state, counter or output changes, in every state.
- All outputs are registered.
- lap_count increments only on an accepted wrap while already in LOCKED. A wrap on the sample that causes lock does not count.

## Timing
- Reset values after any edge with init=1: state=SEARCH, index=0, prev_idx=0, run_cnt=0, locked=0, err=0, err_code=00, lap_count=0.
- Latency is 1 cycle from a sampled edge to the updated index, locked, err or lap_count.
- With LOCK_CNT=3 and en=1 every cycle, locked rises on the edge that samples the 3rd consecutive correct word.
- init mid-operation, in any state: the reset values apply on that edge. `ring` is not sampled on that edge.
- Simultaneous init and en: init wins.
- If the ring counter and ring_decoder share init, ring_decoder sees 10000000 as its first sample after init deasserts. That sample is accepted in SEARCH with index=7.
- Wrap: idx WIDTH-1→0 is a legal step, never a fault.

## Test plan
- Shared init with the ring counter, then free run with en=1. Samples 10000000, 00000001, 00000010 give index 7, 0, 1. locked rises on the edge sampling 00000010. err stays 0.
- Locked and running for 17 further samples (from 00000010 through two 7→0 wraps): lap_count=2, index follows p mod 8.
- While locked, force ring=00000000: the next edge gives err=1, err_code=01, locked=0. index holds its last value. Stays so for 10 cycles of good data until init pulses, then all reset values.
- While locked, hold ring at 00001000 for two samples: the second sample gives err=1, err_code=10.
- Pre-lock glitches: 10000000, 00000001, 00000011, then 00000100, 00001000, 00010000 give no err. The first three samples produce no lock; locked rises only on the edge sampling 00010000.
- en toggling: en=0 for 5 cycles while ring changes arbitrarily leaves index, lap_count and locked unchanged. Correct tracking resumes when en=1 with the next expected word.
